// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// All outputs are registered; a wait counter aborts a grant that never receives mem_ack.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  state_t      r_state, w_next_state;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_last_d, w_last_d;   // 1 = data was granted last, 0 = fetch
  logic        r_mem_req, w_mem_req;
  logic        r_mem_we, w_mem_we;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic [31:0] r_mem_wdata, w_mem_wdata;
  logic [3:0]  r_mem_be, w_mem_be;
  logic [31:0] r_if_rdata, w_if_rdata;
  logic [31:0] r_d_rdata, w_d_rdata;
  logic        r_if_done, w_if_done;
  logic        r_d_done, w_d_done;
  logic        r_err, w_err;

  logic        w_pick_d;
  logic        w_expired;

  // Data wins when it is alone, or on a tie when fetch was served last.
  assign w_pick_d  = d_req && (!if_req || !r_last_d);
  assign w_expired = (r_cnt == LP_TIMEOUT);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    w_next_state = r_state;
    w_cnt        = r_cnt;
    w_last_d     = r_last_d;
    w_mem_req    = r_mem_req;
    w_mem_we     = r_mem_we;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_mem_be     = r_mem_be;
    w_if_rdata   = r_if_rdata;
    w_d_rdata    = r_d_rdata;
    w_if_done    = 1'b0;
    w_d_done     = 1'b0;
    w_err        = 1'b0;

    case (r_state)
      IDLE: begin
        if (if_req || d_req) begin
          w_cnt     = 4'd0;
          w_mem_req = 1'b1;
          if (w_pick_d) begin
            w_next_state = GNT_D;
            w_mem_addr   = d_addr;
            w_mem_we     = d_we;
            w_mem_wdata  = d_wdata;
            w_mem_be     = d_we ? d_be : 4'hF;
          end else begin
            w_next_state = GNT_IF;
            w_mem_addr   = if_addr;
            w_mem_we     = 1'b0;
            w_mem_wdata  = 32'h0;
            w_mem_be     = 4'hF;
          end
        end
      end

      GNT_IF, GNT_D: begin
        if (mem_ack || w_expired) begin
          w_next_state = IDLE;
          w_mem_req    = 1'b0;
          w_last_d     = (r_state == GNT_D);
          w_err        = !mem_ack;
          if (r_state == GNT_IF) begin
            w_if_done  = 1'b1;
            w_if_rdata = mem_ack ? mem_rdata : 32'h0;
          end else begin
            w_d_done = 1'b1;
            if (!mem_ack)
              w_d_rdata = 32'h0;
            else if (!r_mem_we)
              w_d_rdata = mem_rdata;
          end
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_last_d    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'h0;
      r_if_rdata  <= 32'h0;
      r_d_rdata   <= 32'h0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt;
      r_last_d    <= w_last_d;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_be    <= w_mem_be;
      r_if_rdata  <= w_if_rdata;
      r_d_rdata   <= w_d_rdata;
      r_if_done   <= w_if_done;
      r_d_done    <= w_d_done;
      r_err       <= w_err;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled on the falling edge,
// with expected values worked out by hand for each scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [168:0] outs;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick(); tick();
    outs = {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, d_rdata,
            if_done, d_done, err, 32'h0};
    total++;
    if (outs !== 169'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rst = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b0) begin
      bad++; $display("FAIL reset_idle: mem_req got %b want 0", mem_req);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      bad++; $display("FAIL fetch_grant: req/we/be/addr got %b/%b/%h/%h want 1/0/f/00000100",
                      mem_req, mem_we, mem_be, mem_addr);
    end
    tick(); tick();
    total++;
    if ({mem_req, if_done, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL fetch_hold: req/done/addr got %b/%b/%h want 1/0/00000100",
                      mem_req, if_done, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    total++;
    if ({if_done, d_done, mem_req, err, if_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0050_0093}) begin
      bad++; $display("FAIL fetch_done: done/ddone/req/err/rdata got %b/%b/%b/%b/%h want 1/0/0/0/00500093",
                      if_done, d_done, mem_req, err, if_rdata);
    end
    tick();
    total++;
    if (if_done !== 1'b0) begin
      bad++; $display("FAIL fetch_pulse: if_done got %b want 0", if_done);
    end
  endtask

  task automatic test_load();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'b0001; d_wdata = 32'h1111_1111;
    tick();
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h3000}) begin
      bad++; $display("FAIL load_grant: req/we/be/addr got %b/%b/%h/%h want 1/0/f/00003000",
                      mem_req, mem_we, mem_be, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    total++;
    if ({d_done, if_done, d_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      bad++; $display("FAIL load_done: done/ifdone/rdata got %b/%b/%h want 1/0/12345678",
                      d_done, if_done, d_rdata);
    end
    tick();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    tick();
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL store_grant: req/we/be/addr/wdata got %b/%b/%h/%h/%h want 1/1/3/00002004/deadbeef",
                      mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    d_addr = 32'h9999; d_wdata = 32'h0;
    tick();
    total++;
    if ({mem_addr, mem_wdata} !== {32'h2004, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL store_stable: addr/wdata got %h/%h want 00002004/deadbeef",
                      mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    total++;
    if ({d_done, mem_req, d_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      bad++; $display("FAIL store_done: done/req/rdata got %b/%b/%h want 1/0/12345678",
                      d_done, mem_req, d_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    tick();
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL timeout_grant: mem_req got %b want 1", mem_req);
    end
    n = 0;
    while (d_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    d_req = 1'b0;
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL timeout_latency: cycles got %0d want 16", n);
    end
    total++;
    if ({err, mem_req, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL timeout_abort: err/req/rdata got %b/%b/%h want 1/0/00000000",
                      err, mem_req, d_rdata);
    end
    tick();
    total++;
    if ({err, d_done, mem_req} !== 3'b000) begin
      bad++; $display("FAIL timeout_pulse: err/done/req got %b/%b/%b want 0/0/0", err, d_done, mem_req);
    end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    tick();
    total++;
    if ({if_done, d_done, err, mem_req} !== 4'b0000) begin
      bad++; $display("FAIL stray_ack: ifdone/ddone/err/req got %b/%b/%b/%b want 0/0/0/0",
                      if_done, d_done, err, mem_req);
    end
    total++;
    if (if_rdata !== 32'h0050_0093) begin
      bad++; $display("FAIL stray_rdata: if_rdata got %h want 00500093", if_rdata);
    end
    if_req = 1'b1; if_addr = 32'h180;
    tick();
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h180}) begin
      bad++; $display("FAIL stray_idle: req/addr got %b/%h want 1/00000180", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    if_req = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({if_done, if_rdata} !== {1'b1, 32'hA5A5_5A5A}) begin
      bad++; $display("FAIL req_drop: done/rdata got %b/%h want 1/a5a55a5a", if_done, if_rdata);
    end
    tick();
  endtask

  task automatic test_tie();
    logic [31:0] exp_addr;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h600 : 32'h500;
      tick();
      total++;
      if ({mem_req, mem_addr} !== {1'b1, exp_addr}) begin
        bad++; $display("FAIL tie_grant%0d: req/addr got %b/%h want 1/%h", i, mem_req, mem_addr, exp_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(i);
      tick();
      mem_ack = 1'b0;
      total++;
      if ({d_done, if_done} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL tie_done%0d: d_done/if_done got %b/%b want %s", i, d_done, if_done,
                        (i % 2 == 0) ? "1/0" : "0/1");
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [168:0] outs;
    if_req = 1'b1; if_addr = 32'h700;
    tick();
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin
      bad++; $display("FAIL rstmid_grant: req/addr got %b/%h want 1/00000700", mem_req, mem_addr);
    end
    rst = 1'b0;
    tick();
    outs = {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, d_rdata,
            if_done, d_done, err, 32'h0};
    total++;
    if (outs !== 169'h0) begin
      bad++; $display("FAIL rstmid_outputs: got %h want 0", outs);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({mem_req, mem_addr, if_done} !== {1'b1, 32'h700, 1'b0}) begin
      bad++; $display("FAIL rstmid_regrant: req/addr/done got %b/%h/%b want 1/00000700/0",
                      mem_req, mem_addr, if_done);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0073;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    total++;
    if ({if_done, if_rdata} !== {1'b1, 32'h0000_0073}) begin
      bad++; $display("FAIL rstmid_done: done/rdata got %b/%h want 1/00000073", if_done, if_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_stray_ack();
    test_req_drop();
    test_tie();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
